// File: rtl/dma_pkg.sv
// Shared types and default geometry for the DMA input stage.
package dma_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int DEPTH_DEF      = 16;
    localparam int PTR_W          = $clog2(DEPTH_DEF);
    localparam int CNT_W          = PTR_W + 1;

    typedef struct packed {
        logic                      last;
        logic [DATA_WIDTH_DEF-1:0] data;
    } beat_t;

    typedef enum logic {
        HOLD,
        RELEASE
    } sf_state_e;

endpackage

// File: rtl/dma_in_stage_if.sv
// Stream handshake bundle between the DMA read path, this stage and compute.
interface dma_in_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  last_in;
    logic                  ready_out;
    logic                  valid_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  last_out;
    logic                  ready_in;

    modport slave (
        input  valid_in, data_in, last_in, ready_in,
        output ready_out, valid_out, data_out, last_out
    );

    modport master (
        output valid_in, data_in, last_in, ready_in,
        input  ready_out, valid_out, data_out, last_out
    );
endinterface

// File: rtl/dma_in_fifo.sv
// Synchronous FIFO with show-ahead read from registered memory.
module dma_in_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (level == CNT_W'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/dma_in_stage.sv
// DMA input stage: FIFO buffering, frame length reporting and optional
// store-and-forward release of whole frames to the compute datapath.
module dma_in_stage
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int LEN_WIDTH  = 16,
    parameter int STORE_FWD  = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dma_in_stage_if.slave          bus,
    output logic [$clog2(DEPTH):0] level,
    output logic [$clog2(DEPTH):0] frame_cnt,
    output logic                   frame_done,
    output logic [LEN_WIDTH-1:0]   frame_len,
    output logic                   oversize
);
    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } stream_beat_t;

    stream_beat_t        wbeat;
    stream_beat_t        rbeat;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic                frame_in;
    logic                frame_out;
    logic                rel_active;
    logic [LEN_WIDTH-1:0] beat_cnt;
    logic [LEN_WIDTH-1:0] len_inc;
    sf_state_e           state;
    sf_state_e           state_nxt;

    dma_in_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wbeat),
        .rdata (rbeat),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    assign wbeat         = '{last: bus.last_in, data: bus.data_in};
    assign bus.ready_out = rst_n & ~full;
    assign push          = bus.valid_in & bus.ready_out;
    assign pop           = bus.valid_out & bus.ready_in;
    assign frame_in      = push & bus.last_in;
    assign frame_out     = pop & bus.last_out;

    // A frame may leave only once fully buffered, unless the FIFO filled
    // before its last beat arrived; then it is streamed through.
    assign rel_active    = (state == RELEASE);
    assign bus.valid_out = rst_n & ~empty &
                           ((STORE_FWD == 0) | (frame_cnt != '0) | rel_active);
    assign bus.data_out  = rbeat.data;
    assign bus.last_out  = rbeat.last & bus.valid_out;

    assign len_inc = (&beat_cnt) ? beat_cnt : beat_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt   <= '0;
            frame_cnt  <= '0;
            frame_len  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_in;
            if (push) begin
                if (bus.last_in) begin
                    frame_len <= len_inc;
                    beat_cnt  <= '0;
                end else begin
                    beat_cnt  <= len_inc;
                end
            end
            case ({frame_in, frame_out})
                2'b10:   frame_cnt <= frame_cnt + 1'b1;
                2'b01:   frame_cnt <= frame_cnt - 1'b1;
                default: frame_cnt <= frame_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= HOLD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        oversize  = 1'b0;
        unique case (state)
            HOLD: begin
                if ((STORE_FWD != 0) && rst_n && full && (frame_cnt == '0)) begin
                    state_nxt = RELEASE;
                    oversize  = 1'b1;
                end
            end
            RELEASE: begin
                if (frame_out) state_nxt = HOLD;
            end
            default: state_nxt = HOLD;
        endcase
    end

endmodule
